// File: rtl/pipelined_adder_nbit.sv
// Pipelined ripple adder/subtractor: one C-bit chunk per stage, registered carry between stages.
// Define ADDER_SAT_EN to clamp sum on signed overflow instead of wrapping.
module pipelined_adder_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int C = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             ovf_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = sub ? ~carryin : carryin;

  // Stage row layout: {b_rest, a_rest, sum_done}. Finished sum chunks replace
  // the consumed a chunks in place, so the row shrinks by C bits per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = 2*WIDTH - k*C;
    localparam int OW = 2*WIDTH - (k+1)*C;

    logic [IW-1:0]    row_in;
    logic             v_in;
    logic             c_in;
    logic [C:0]       part;
    logic [WIDTH-1:0] lo;
    logic [OW-1:0]    row_next;
    logic [OW-1:0]    row_q;
    logic             v_q;
    logic             c_q;

    if (k == 0) begin : g_first
      assign row_in = {b_eff, a};
      assign v_in   = in_valid;
      assign c_in   = cin_eff;
    end else begin : g_chain
      assign row_in = g_stage[k-1].row_q;
      assign v_in   = g_stage[k-1].v_q;
      assign c_in   = g_stage[k-1].c_q;
    end

    assign part = {1'b0, row_in[k*C +: C]} + {1'b0, row_in[WIDTH +: C]} + {{C{1'b0}}, c_in};

    always_comb begin
      lo = row_in[WIDTH-1:0];
      lo[k*C +: C] = part[C-1:0];
    end

    if (k == STAGES-1) begin : g_last
      logic ovf;
      // Carry into the MSB is recovered from the MSB sum bit and both operand MSBs.
      assign ovf = row_in[WIDTH-1] ^ row_in[WIDTH+C-1] ^ part[C-1] ^ part[C];

      always_comb begin
        row_next = lo;
`ifdef ADDER_SAT_EN
        if (ovf) begin
          row_next = row_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          ovf_q <= ovf;
        end
      end
    end else begin : g_mid
      assign row_next = {row_in[IW-1:WIDTH+C], lo};
    end

    // Data registers only load on valid transfers; bubbles leave them untouched.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        row_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        if (v_in) begin
          c_q   <= part[C];
          row_q <= row_next;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign carryout  = g_stage[STAGES-1].c_q;
  assign sum       = g_stage[STAGES-1].row_q;
  assign overflow  = ovf_q;

endmodule
